// File: rtl/b_resp_arbiter_if.sv
// B-response collector bundle: per-source show-ahead FIFO read sides plus the AXI B channel to the master.
// Latency: none, this is a wiring bundle only.
// Backpressure: BREADY from the master throttles the FIFO pops issued by the arbiter.
//
// Ports carried:
//   fifo_empty [NUM_SRC]           per-FIFO empty flag, bit i is FIFO i
//   fifo_BID   [NUM_SRC*ID_WIDTH]  front BID of FIFO i at [i*ID_WIDTH +: ID_WIDTH]
//   fifo_BRESP [NUM_SRC*2]         front BRESP of FIFO i at [i*2 +: 2]
//   fifo_pop   [NUM_SRC]           one-hot pop strobe back to the FIFOs
//   BID/BRESP/BVALID/BREADY        AXI B channel toward the master
//   grant_idx  [3]                 source index of the response held in the output slot
//   err_cnt/err_clr                error-response counter, only with B_ERR_CNT_EN defined
//
// Modport "master" is the arbiter's view (it masters the FIFO pops and drives the B channel);
// modport "slave" is the surrounding FIFOs plus the AXI master.

interface b_resp_arbiter_if #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_SRC  = 2
);
    logic [NUM_SRC-1:0]          fifo_empty;
    logic [NUM_SRC*ID_WIDTH-1:0] fifo_BID;
    logic [NUM_SRC*2-1:0]        fifo_BRESP;
    logic [NUM_SRC-1:0]          fifo_pop;
    logic [ID_WIDTH-1:0]         BID;
    logic [1:0]                  BRESP;
    logic                        BVALID;
    logic                        BREADY;
    logic [2:0]                  grant_idx;
`ifdef B_ERR_CNT_EN
    logic [15:0]                 err_cnt;
    logic                        err_clr;

    modport master (
        input  fifo_empty, fifo_BID, fifo_BRESP, BREADY, err_clr,
        output fifo_pop, BID, BRESP, BVALID, grant_idx, err_cnt
    );

    modport slave (
        output fifo_empty, fifo_BID, fifo_BRESP, BREADY, err_clr,
        input  fifo_pop, BID, BRESP, BVALID, grant_idx, err_cnt
    );
`else
    modport master (
        input  fifo_empty, fifo_BID, fifo_BRESP, BREADY,
        output fifo_pop, BID, BRESP, BVALID, grant_idx
    );

    modport slave (
        output fifo_empty, fifo_BID, fifo_BRESP, BREADY,
        input  fifo_pop, BID, BRESP, BVALID, grant_idx
    );
`endif

endinterface

// File: rtl/b_resp_arbiter.sv
// Round-robin collector draining up to NUM_SRC show-ahead B-response FIFOs into one AXI B channel.
// Latency: 1 cycle from FIFO front to BVALID; 1 response/cycle sustained while BREADY is held high.
// Backpressure: a full output slot with BREADY low blocks all pops and freezes priority rotation.
//
// Ports:
//   clk   master-domain clock
//   nrst  asynchronous active-low reset; also forces fifo_pop low immediately
//   bus   b_resp_arbiter_if.master (FIFO read sides + AXI B channel + grant_idx)
//
// Parameters: ID_WIDTH (BID width), NUM_SRC (1..8 source FIFOs).
// Optional macro B_ERR_CNT_EN: adds a saturating 16-bit count of SLVERR/DECERR handshakes
// (bus.err_cnt) with a synchronous clear (bus.err_clr). Without it the counter does not exist.

module b_resp_arbiter #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_SRC  = 2
) (
    input  logic              clk,
    input  logic              nrst,
    b_resp_arbiter_if.master  bus
);

    localparam logic [2:0] LAST_RST = 3'(NUM_SRC - 1);

    // Output slot
    logic                bvalid_q;
    logic [ID_WIDTH-1:0] bid_q;
    logic [1:0]          bresp_q;
    logic [2:0]          grant_idx_q;

    // Index of the most recently popped source; the search starts just after it.
    logic [2:0]          last_q;

    // Arbitration
    logic                hi_any;
    logic [2:0]          hi_sel;
    logic                lo_any;
    logic [2:0]          lo_sel;
    logic                grant_any;
    logic [2:0]          grant_sel;
    logic [NUM_SRC-1:0]  grant;
    logic                load_en;
    logic                pop_any;
    logic [ID_WIDTH-1:0] sel_bid;
    logic [1:0]          sel_bresp;

    // The slot can take a new response when empty or when it is being drained this cycle.
    assign load_en = !bvalid_q || bus.BREADY;

    // Round-robin search without a modulo: the winner is the lowest-numbered requester
    // above last_q; if there is none the search has wrapped, so take the lowest-numbered
    // requester overall (which may be last_q itself when it is the only one).
    always_comb begin
        hi_any = 1'b0;
        hi_sel = '0;
        lo_any = 1'b0;
        lo_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!bus.fifo_empty[i]) begin
                lo_any = 1'b1;
                lo_sel = 3'(i);
                if (3'(i) > last_q) begin
                    hi_any = 1'b1;
                    hi_sel = 3'(i);
                end
            end
        end
        grant_any = hi_any || lo_any;
        grant_sel = hi_any ? hi_sel : lo_sel;
    end

    always_comb begin
        grant     = '0;
        sel_bid   = '0;
        sel_bresp = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_any && (3'(i) == grant_sel)) begin
                grant[i] = 1'b1;
            end
            if (3'(i) == grant_sel) begin
                sel_bid   = bus.fifo_BID[i*ID_WIDTH +: ID_WIDTH];
                sel_bresp = bus.fifo_BRESP[i*2 +: 2];
            end
        end
    end

    assign pop_any = grant_any && load_en;

    // Gated by nrst directly so the pop drops the moment reset asserts, not at the next edge.
    assign bus.fifo_pop = nrst ? (grant & {NUM_SRC{load_en}}) : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            grant_idx_q <= '0;
            last_q      <= LAST_RST;
        end else if (pop_any) begin
            bvalid_q    <= 1'b1;
            bid_q       <= sel_bid;
            bresp_q     <= sel_bresp;
            grant_idx_q <= grant_sel;
            last_q      <= grant_sel;
        end else if (bvalid_q && bus.BREADY) begin
            // Slot drained with nothing to refill it; BID/BRESP keep stale values.
            bvalid_q    <= 1'b0;
        end
    end

    assign bus.BVALID    = bvalid_q;
    assign bus.BID       = bid_q;
    assign bus.BRESP     = bresp_q;
    assign bus.grant_idx = grant_idx_q;

`ifdef B_ERR_CNT_EN
    logic [15:0] err_q;
    logic        err_hit;

    // BRESP[1] set covers both SLVERR and DECERR.
    assign err_hit = bvalid_q && bus.BREADY && bresp_q[1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_q <= '0;
        end else if (bus.err_clr) begin
            // Clear wins over a coincident error.
            err_q <= '0;
        end else if (err_hit && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign bus.err_cnt = err_q;
`endif

    // Structural invariants of the pop strobe.
    a_pop_onehot : assert property (@(posedge clk) disable iff (!nrst)
        $onehot0(bus.fifo_pop));
    a_pop_nonempty : assert property (@(posedge clk) disable iff (!nrst)
        ((bus.fifo_pop & bus.fifo_empty) == '0));

endmodule

// File: tb/tb_b_resp_arbiter.sv
module tb_b_resp_arbiter;

    logic clk;
    logic nrst;

    b_resp_arbiter_if #(.ID_WIDTH(4), .NUM_SRC(2)) if2 ();
    b_resp_arbiter_if #(.ID_WIDTH(4), .NUM_SRC(4)) if4 ();

    b_resp_arbiter #(.ID_WIDTH(4), .NUM_SRC(2)) u_dut2 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (if2.master)
    );

    b_resp_arbiter #(.ID_WIDTH(4), .NUM_SRC(4)) u_dut4 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (if4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] src;
        logic [3:0] id;
        logic [1:0] rs;
    } exp_t;

    typedef struct {
        logic [3:0] mask;     // which FIFOs get one entry
        logic [3:0] exp_pop;  // expected one-hot pop
        logic [2:0] exp_src;  // expected winner
    } vec_t;

    exp_t sb2[$];
    exp_t sb4[$];

    logic [3:0] m2_id [2][8];
    logic [1:0] m2_rs [2][8];
    int         rd2 [2];
    int         wr2 [2];
    logic [3:0] m4_id [4][8];
    logic [1:0] m4_rs [4][8];
    int         rd4 [4];
    int         wr4 [4];

    int n_chk  = 0;
    int n_pass = 0;

    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if2.fifo_empty[s]       = (rd2[s] == wr2[s]);
            if2.fifo_BID[s*4 +: 4]  = m2_id[s][rd2[s] & 7];
            if2.fifo_BRESP[s*2 +: 2] = m2_rs[s][rd2[s] & 7];
        end
        for (int s = 0; s < 4; s++) begin
            if4.fifo_empty[s]       = (rd4[s] == wr4[s]);
            if4.fifo_BID[s*4 +: 4]  = m4_id[s][rd4[s] & 7];
            if4.fifo_BRESP[s*2 +: 2] = m4_rs[s][rd4[s] & 7];
        end
    endtask

    task automatic load2(input int s, input logic [3:0] id, input logic [1:0] rs);
        m2_id[s][wr2[s] & 7] = id;
        m2_rs[s][wr2[s] & 7] = rs;
        wr2[s]++;
    endtask

    task automatic load4(input int s, input logic [3:0] id, input logic [1:0] rs);
        m4_id[s][wr4[s] & 7] = id;
        m4_rs[s][wr4[s] & 7] = rs;
        wr4[s]++;
    endtask

    task automatic expect2(input int s, input logic [3:0] id, input logic [1:0] rs);
        exp_t e;
        e.src = 3'(s); e.id = id; e.rs = rs;
        sb2.push_back(e);
    endtask

    task automatic expect4(input int s, input logic [3:0] id, input logic [1:0] rs);
        exp_t e;
        e.src = 3'(s); e.id = id; e.rs = rs;
        sb4.push_back(e);
    endtask

    // One clock: compare any handshake about to happen against the scoreboards,
    // then advance the FIFO models by the pops that were asserted at the edge.
    task automatic tick();
        logic [1:0] p2;
        logic [3:0] p4;
        exp_t e;
        p2 = if2.fifo_pop;
        p4 = if4.fifo_pop;
        if (if2.BVALID && if2.BREADY) begin
            check("dut2.sb_has_entry", 32'(sb2.size() != 0), 1);
            if (sb2.size() != 0) begin
                e = sb2.pop_front();
                check("dut2.BID", 32'(if2.BID), 32'(e.id));
                check("dut2.BRESP", 32'(if2.BRESP), 32'(e.rs));
                check("dut2.grant_idx", 32'(if2.grant_idx), 32'(e.src));
            end
        end
        if (if4.BVALID && if4.BREADY) begin
            check("dut4.sb_has_entry", 32'(sb4.size() != 0), 1);
            if (sb4.size() != 0) begin
                e = sb4.pop_front();
                check("dut4.BID", 32'(if4.BID), 32'(e.id));
                check("dut4.BRESP", 32'(if4.BRESP), 32'(e.rs));
                check("dut4.grant_idx", 32'(if4.grant_idx), 32'(e.src));
            end
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) if (p2[s]) rd2[s]++;
        for (int s = 0; s < 4; s++) if (p4[s]) rd4[s]++;
        drive();
        #1;
    endtask

    task automatic rst_pulse();
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        #1;
    endtask

    function automatic logic [3:0] vid(input int r, input int s);
        return 4'(r * 3 + s * 5);
    endfunction

    function automatic logic [1:0] vrs(input int r, input int s);
        return 2'(r + s);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{4'b1111, 4'b0001, 3'd0};
        vt[1]  = '{4'b1111, 4'b0010, 3'd1};
        vt[2]  = '{4'b0001, 4'b0001, 3'd0};
        vt[3]  = '{4'b1000, 4'b1000, 3'd3};  // last=0, only FIFO3: skip empties
        vt[4]  = '{4'b0110, 4'b0010, 3'd1};
        vt[5]  = '{4'b0101, 4'b0100, 3'd2};
        vt[6]  = '{4'b0011, 4'b0001, 3'd0};
        vt[7]  = '{4'b0000, 4'b0000, 3'd0};
        vt[8]  = '{4'b1010, 4'b0010, 3'd1};
        vt[9]  = '{4'b1001, 4'b1000, 3'd3};
        vt[10] = '{4'b1111, 4'b0001, 3'd0};

        for (int s = 0; s < 2; s++) begin rd2[s] = 0; wr2[s] = 0; end
        for (int s = 0; s < 4; s++) begin rd4[s] = 0; wr4[s] = 0; end
        for (int s = 0; s < 2; s++) for (int k = 0; k < 8; k++) begin m2_id[s][k] = '0; m2_rs[s][k] = '0; end
        for (int s = 0; s < 4; s++) for (int k = 0; k < 8; k++) begin m4_id[s][k] = '0; m4_rs[s][k] = '0; end
        nrst = 1'b0;
        if2.BREADY = 1'b1;
        if4.BREADY = 1'b1;
`ifdef B_ERR_CNT_EN
        if2.err_clr = 1'b0;
        if4.err_clr = 1'b0;
`endif
        // ---- Reset and single response ----
        load2(0, 4'h3, 2'b00);
        drive();
        repeat (2) @(posedge clk);
        #2;
        check("rst.fifo_pop_gated", 32'(if2.fifo_pop), 0);
        check("rst.BVALID", 32'(if2.BVALID), 0);
        check("rst.BID", 32'(if2.BID), 0);
        check("rst.BRESP", 32'(if2.BRESP), 0);
        check("rst.grant_idx", 32'(if2.grant_idx), 0);
        check("rst.dut4.BVALID", 32'(if4.BVALID), 0);
        nrst = 1'b1;
        #1;
        check("single.fifo_pop", 32'(if2.fifo_pop), 32'h1);
        expect2(0, 4'h3, 2'b00);
        tick();
        check("single.BVALID", 32'(if2.BVALID), 1);
        check("single.BID", 32'(if2.BID), 3);
        check("single.BRESP", 32'(if2.BRESP), 0);
        check("single.grant_idx", 32'(if2.grant_idx), 0);
        tick();
        check("single.BVALID_drop", 32'(if2.BVALID), 0);

        // ---- Round-robin fairness, no bubbles ----
        rst_pulse();
        load2(0, 4'h1, 2'd0); load2(0, 4'h2, 2'd1); load2(0, 4'h3, 2'd2);
        load2(1, 4'h9, 2'd3); load2(1, 4'hA, 2'd0); load2(1, 4'hB, 2'd1);
        expect2(0, 4'h1, 2'd0); expect2(1, 4'h9, 2'd3);
        expect2(0, 4'h2, 2'd1); expect2(1, 4'hA, 2'd0);
        expect2(0, 4'h3, 2'd2); expect2(1, 4'hB, 2'd1);
        drive();
        #1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr.BVALID_c%0d", k), 32'(if2.BVALID), 1);
        end
        tick();
        check("rr.BVALID_end", 32'(if2.BVALID), 0);

        // ---- Backpressure ----
        if2.BREADY = 1'b0;
        load2(0, 4'h5, 2'b01);
        load2(1, 4'h6, 2'b10);
        drive();
        #1;
        check("bp.first_pop", 32'(if2.fifo_pop), 32'h1);
        expect2(0, 4'h5, 2'b01);
        expect2(1, 4'h6, 2'b10);
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp.BID_c%0d", k), 32'(if2.BID), 5);
            check($sformatf("bp.BRESP_c%0d", k), 32'(if2.BRESP), 1);
            check($sformatf("bp.gidx_c%0d", k), 32'(if2.grant_idx), 0);
            check($sformatf("bp.pop_c%0d", k), 32'(if2.fifo_pop), 0);
            tick();
        end
        if2.BREADY = 1'b1;
        #1;
        check("bp.release_pop", 32'(if2.fifo_pop), 32'h2);
        tick();
        check("bp.next_BVALID", 32'(if2.BVALID), 1);
        check("bp.next_BID", 32'(if2.BID), 6);
        tick();
        check("bp.BVALID_end", 32'(if2.BVALID), 0);

        // ---- Reset mid-stall ----
        if2.BREADY = 1'b0;
        load2(0, 4'h7, 2'b00);
        load2(1, 4'h8, 2'b11);
        drive();
        #1;
        tick();
        check("ms.held_BVALID", 32'(if2.BVALID), 1);
        nrst = 1'b0;
        #1;
        check("ms.rst_BVALID", 32'(if2.BVALID), 0);
        check("ms.rst_pop", 32'(if2.fifo_pop), 0);
        load2(0, 4'hC, 2'b01);
        nrst = 1'b1;
        drive();
        #1;
        check("ms.prio0_pop", 32'(if2.fifo_pop), 32'h1);
        expect2(0, 4'hC, 2'b01);
        expect2(1, 4'h8, 2'b11);
        if2.BREADY = 1'b1;
        repeat (3) tick();
        check("ms.BVALID_end", 32'(if2.BVALID), 0);

        // ---- Table-driven arbitration on the 4-source instance ----
        for (int r = 0; r < 11; r++) begin
            for (int s = 0; s < 4; s++)
                if (vt[r].mask[s]) load4(s, vid(r, s), vrs(r, s));
            drive();
            #1;
            check($sformatf("vec%0d.fifo_pop", r), 32'(if4.fifo_pop), 32'(vt[r].exp_pop));
            if (vt[r].exp_pop != 4'b0000)
                expect4(int'(vt[r].exp_src), vid(r, int'(vt[r].exp_src)), vrs(r, int'(vt[r].exp_src)));
            tick();
            for (int s = 0; s < 4; s++) rd4[s] = wr4[s];
            drive();
            #1;
            check($sformatf("vec%0d.BVALID", r), 32'(if4.BVALID), 32'(vt[r].exp_pop != 4'b0000));
            tick();
            check($sformatf("vec%0d.BVALID_end", r), 32'(if4.BVALID), 0);
        end

`ifdef B_ERR_CNT_EN
        // ---- Error counter ----
        rst_pulse();
        check("err.reset", 32'(if2.err_cnt), 0);
        load2(0, 4'h1, 2'b10); load2(0, 4'h2, 2'b00); load2(0, 4'h3, 2'b11);
        expect2(0, 4'h1, 2'b10); expect2(0, 4'h2, 2'b00); expect2(0, 4'h3, 2'b11);
        drive();
        #1;
        repeat (4) tick();
        check("err.count2", 32'(if2.err_cnt), 2);
        load2(0, 4'h4, 2'b11);
        expect2(0, 4'h4, 2'b11);
        drive();
        #1;
        tick();
        if2.err_clr = 1'b1;
        tick();
        if2.err_clr = 1'b0;
        check("err.clr_wins", 32'(if2.err_cnt), 0);
        u_dut2.err_q = 16'hFFFE;
        load2(0, 4'h5, 2'b10); load2(0, 4'h6, 2'b11);
        expect2(0, 4'h5, 2'b10); expect2(0, 4'h6, 2'b11);
        drive();
        #1;
        tick();
        tick();
        check("err.reach_max", 32'(if2.err_cnt), 32'hFFFF);
        tick();
        check("err.saturate", 32'(if2.err_cnt), 32'hFFFF);
`endif

        check("sb2.drained", 32'(sb2.size()), 0);
        check("sb4.drained", 32'(sb4.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/b_resp_arbiter.md
Name: b_resp_arbiter

Overview:
- Master-side B-channel collector: drains up to NUM_SRC per-slave B response FIFOs (show-ahead async FIFO read sides, all in the master clock domain) into one AXI B channel toward a master.
- Round-robin arbitration between non-empty FIFOs; a single registered output slot drives BVALID/BID/BRESP with a full BREADY handshake.
- Sits directly downstream of the B response FIFOs, one instance per master port of the crossbar.

Parameters:
- ID_WIDTH, 4, width of BID.
- NUM_SRC, 2, number of source FIFOs (slave ports); legal range 1..8.

Ports:
- clk  input  1  master-domain clock.
- nrst  input  1  asynchronous active-low reset.
- fifo_empty  input  NUM_SRC  per-FIFO empty flag; bit i is FIFO i.
- fifo_BID  input  NUM_SRC*ID_WIDTH  front BID of each FIFO; FIFO i at [i*ID_WIDTH +: ID_WIDTH].
- fifo_BRESP  input  NUM_SRC*2  front BRESP of each FIFO; FIFO i at [i*2 +: 2].
- fifo_pop  output  NUM_SRC  one-hot pop strobe, combinational.
- BID  output  ID_WIDTH  AXI BID to master.
- BRESP  output  2  AXI BRESP to master.
- BVALID  output  1  AXI BVALID.
- BREADY  input  1  AXI BREADY from master.
- grant_idx  output  3  index of the source loaded into the output slot; valid while BVALID=1.

Behaviour:
- Reset (async, nrst=0):
  - BVALID=0, BID=0, BRESP=0, grant_idx=0.
  - Round-robin pointer last=NUM_SRC-1, so source 0 has first priority.
  - fifo_pop=0 regardless of other inputs while nrst=0.
- FIFO inputs are show-ahead: front data is valid whenever fifo_empty[i]=0.
- load_en = !BVALID || BREADY. The output slot accepts a new response when it is empty or is being drained this cycle.
- Arbitration (combinational):
  - Search sources in order last+1, last+2, … with wrap modulo NUM_SRC.
  - The first source with fifo_empty=0 wins (grant, one-hot).
  - No request means no grant.
- fifo_pop = grant & {NUM_SRC{load_en}}.
  - At most one bit set.
  - Never asserted for an empty FIFO.
- On a clock edge with a pop of source k:
  - BID/BRESP take source k's front data.
  - BVALID=1, grant_idx=k, last=k.
- On a clock edge with BVALID && BREADY and no pop: BVALID=0. BID/BRESP hold their values; they are don't-care.
- Otherwise all outputs and last hold.
- Latency: FIFO front to BVALID is 1 cycle.
- Throughput: 1 response per cycle when BREADY is held high (back-to-back pop and handshake in the same cycle).
- Stability: while BVALID=1 && BREADY=0, BID/BRESP/grant_idx are stable and fifo_pop=0.
- BVALID never depends combinationally on BREADY.
- last advances only on a pop. A stalled slot does not rotate priority.
- NUM_SRC=1: grant = !fifo_empty[0]; grant_idx is always 0.
- Reset mid-operation: a held response is dropped; fifo_pop deasserts immediately (asynchronously).

Optional Feature:
- Macro B_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, 16 bits.
  - Counts completed handshakes (BVALID && BREADY) with BRESP[1]=1 (SLVERR=2'b10, DECERR=2'b11).
  - Saturates at 16'hFFFF; reset value 0.
  - Adds input err_clr, 1 bit: synchronous clear to 0. If err_clr and a counted handshake coincide, the result is 0.
- Not defined: no err_cnt/err_clr ports and no counter logic. All other behaviour is identical.

Test Plan:
- Reset and single response: nrst low, then release; FIFO0 holds {BID=4'h3, BRESP=2'b00}, BREADY=1. Expect fifo_pop=2'b01 in cycle 0; next cycle BVALID=1, BID=3, BRESP=0, grant_idx=0; BVALID=0 in the following cycle.
- Round-robin fairness: NUM_SRC=2, both FIFOs hold 3 entries (FIFO0 IDs 1,2,3; FIFO1 IDs 9,A,B), BREADY=1. Expect BID sequence 1,9,2,A,3,B on 6 consecutive cycles with no bubbles.
- Backpressure: one response loaded, BREADY=0 for 5 cycles, FIFO1 non-empty. Expect BID/BRESP stable and fifo_pop=0 for all 5 cycles. BREADY=1 gives the handshake plus a FIFO1 pop in the same cycle, and the new BVALID next cycle with no gap.
- Empty-source skip: NUM_SRC=4, last=0, only FIFO3 non-empty. Expect grant of source 3, fifo_pop=4'b1000, grant_idx=3.
- Reset mid-stall: BVALID=1, BREADY=0, assert nrst=0 asynchronously. Expect BVALID=0 and fifo_pop=0 before the next edge; after release, source 0 has priority again.
- B_ERR_CNT_EN: 3 handshakes with BRESP=2'b10, 2'b00, 2'b11. Expect err_cnt=2. Then err_clr=1 coinciding with a DECERR handshake gives err_cnt=0. A preload near 16'hFFFF stays at 16'hFFFF after one more error.
